// File: rtl/ahb_pkg.sv
// Shared encodings for the simplified AHB fabric: response/transfer codes
// and the initiator FSM state type.
package ahb_pkg;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01,
    HRESP_RETRY = 2'b10,
    HRESP_SPLIT = 2'b11
  } hresp_t;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [1:0] {
    MST_IDLE,
    MST_REQ,
    MST_ADDR,
    MST_DATA
  } ahb_master_state_t;

endpackage

// File: rtl/ahb_master.sv
// Single-transfer AHB initiator: accepts one local command, arbitrates for
// the bus, runs one NONSEQ transfer and returns a one-cycle response.
module ahb_master
  import ahb_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_RETRY = 4
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              hbusreq,
  input  logic              hgrant,
  output logic [ADDR_W-1:0] haddr,
  output logic              hwrite,
  output logic [DATA_W-1:0] hwdata,
  output logic [1:0]        htrans,
  input  logic              hready,
  input  logic [1:0]        hresp,
  input  logic [DATA_W-1:0] hrdata
);

  localparam int unsigned     CNT_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_RETRY);

  ahb_master_state_t  state;
  logic [DATA_W-1:0]  wdata_q;
  logic [CNT_W-1:0]   retry_cnt;
  logic [CNT_W-1:0]   retry_next;
  logic               retry_limit;

  always_comb begin
    retry_next  = (retry_cnt == CNT_MAX) ? retry_cnt : retry_cnt + 1'b1;
    retry_limit = (retry_next >= CNT_MAX);
  end

  // Masking with rsp_valid keeps the response cycle from doubling as an accept cycle.
  always_comb cmd_ready = (state == MST_IDLE) && !rsp_valid;

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state     <= MST_IDLE;
      hbusreq   <= 1'b0;
      htrans    <= HTRANS_IDLE;
      haddr     <= '0;
      hwrite    <= 1'b0;
      hwdata    <= '0;
      wdata_q   <= '0;
      retry_cnt <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      case (state)
        MST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            haddr     <= cmd_addr;
            hwrite    <= cmd_write;
            wdata_q   <= cmd_wdata;
            retry_cnt <= '0;
            hbusreq   <= 1'b1;
            state     <= MST_REQ;
          end
        end
        MST_REQ: begin
          // Request is low only for the single cycle after a SPLIT.
          if (!hbusreq) begin
            hbusreq <= 1'b1;
          end else if (hgrant && hready) begin
            htrans <= HTRANS_NONSEQ;
            state  <= MST_ADDR;
          end
        end
        MST_ADDR: begin
          htrans <= HTRANS_IDLE;
          hwdata <= hwrite ? wdata_q : '0;
          state  <= MST_DATA;
        end
        MST_DATA: begin
          if (hready) begin
            hwdata <= '0;
            case (hresp_t'(hresp))
              HRESP_OKAY: begin
                rsp_valid <= 1'b1;
                if (!hwrite) rsp_rdata <= hrdata;
                hbusreq   <= 1'b0;
                state     <= MST_IDLE;
              end
              HRESP_ERROR: begin
                rsp_valid <= 1'b1;
                rsp_err   <= 1'b1;
                hbusreq   <= 1'b0;
                state     <= MST_IDLE;
              end
              HRESP_RETRY: begin
                retry_cnt <= retry_next;
                if (retry_limit) begin
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                  hbusreq   <= 1'b0;
                  state     <= MST_IDLE;
                end else begin
                  state <= MST_REQ;
                end
              end
              HRESP_SPLIT: begin
                hbusreq <= 1'b0;
                state   <= MST_REQ;
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_master.sv
// Randomised bench for ahb_master: reactive slave/arbiter, cycle-level
// behavioural model checked every cycle, plus directed literal expectations.
module tb_ahb_master;
  import ahb_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned MR = 4;

  logic          hclk = 1'b0;
  logic          hreset = 1'b1;
  logic          cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          cmd_ready, rsp_valid, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          hbusreq, hwrite;
  logic          hgrant = 1'b1, hready = 1'b1;
  logic [AW-1:0] haddr;
  logic [DW-1:0] hwdata;
  logic [1:0]    htrans;
  logic [1:0]    hresp = 2'b00;
  logic [DW-1:0] hrdata = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  ahb_master #(.ADDR_W(AW), .DATA_W(DW), .MAX_RETRY(MR)) dut (
    .hclk(hclk), .hreset(hreset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .hbusreq(hbusreq), .hgrant(hgrant), .haddr(haddr), .hwrite(hwrite),
    .hwdata(hwdata), .htrans(htrans), .hready(hready), .hresp(hresp),
    .hrdata(hrdata)
  );

  always #5 hclk = ~hclk;
  always @(posedge hclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- slave / arbiter environment ----------------
  typedef struct {
    int            waits;
    logic [1:0]    resp;
    logic [DW-1:0] data;
  } dresp_t;

  dresp_t rq[$];
  int     grant_block = 0;
  int     split_block = 10;
  bit     grant_random = 0, idle_random = 0, split_rand = 0;

  task automatic push(input int w, input logic [1:0] r, input logic [DW-1:0] d);
    dresp_t e;
    e.waits = w; e.resp = r; e.data = d;
    rq.push_back(e);
  endtask

  function automatic dresp_t rand_resp();
    dresp_t d;
    int r;
    r = $urandom_range(0, 99);
    d.waits = $urandom_range(0, 3);
    d.data  = $urandom;
    if (r < 60)      d.resp = HRESP_OKAY;
    else if (r < 75) d.resp = HRESP_ERROR;
    else if (r < 90) d.resp = HRESP_RETRY;
    else             d.resp = HRESP_SPLIT;
    return d;
  endfunction

  initial begin : slave
    bit     addr_seen, in_d;
    int     wl;
    dresp_t cur;
    in_d = 0; wl = 0;
    cur = rand_resp();
    forever begin
      @(negedge hclk);
      addr_seen = (htrans == HTRANS_NONSEQ);
      @(posedge hclk); #2;
      if (hreset) begin
        in_d = 0; rq.delete(); grant_block = 0;
        hgrant = 1'b1; hready = 1'b1; hresp = HRESP_OKAY;
        continue;
      end
      if (grant_block > 0) begin
        hgrant = 1'b0;
        grant_block--;
      end else begin
        hgrant = grant_random ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      if (addr_seen) begin
        if (rq.size() > 0) cur = rq.pop_front();
        else cur = rand_resp();
        in_d = 1; wl = cur.waits;
      end
      if (in_d) begin
        if (wl > 0) begin
          hready = 1'b0;
          hresp  = idle_random ? 2'($urandom_range(0, 3)) : HRESP_OKAY;
          hrdata = $urandom;
          wl--;
        end else begin
          hready = 1'b1; hresp = cur.resp; hrdata = cur.data; in_d = 0;
          if (cur.resp == HRESP_SPLIT)
            grant_block = split_rand ? $urandom_range(0, 4) : split_block;
        end
      end else begin
        hready = idle_random ? ($urandom_range(0, 4) != 0) : 1'b1;
        hresp  = idle_random ? 2'($urandom_range(0, 3)) : HRESP_OKAY;
        hrdata = $urandom;
      end
    end
  end

  // ---------------- behavioural model + per-cycle compare ----------------
  logic          m_ok = 0, m_busy = 0, m_issued = 0, m_fresh = 1, m_write = 0, m_err = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0, m_rdata = '0;
  int            m_req_from = 0, m_addr_at = 0, m_rsp_at = -1, m_gap_at = -1, m_retries = 0;
  logic          e_data;

  initial begin : model
    forever begin
      @(negedge hclk);
      if (m_ok) begin
        e_data = m_busy && m_issued && (cyc > m_addr_at);
        chk("hbusreq", hbusreq, m_busy && (cyc != m_gap_at));
        chk("htrans", htrans, (m_busy && m_issued && cyc == m_addr_at) ? 2'b10 : 2'b00);
        chk("rsp_valid", rsp_valid, cyc == m_rsp_at);
        chk("cmd_ready", cmd_ready, !m_busy && (cyc != m_rsp_at));
        chk("rsp_rdata", rsp_rdata, m_rdata);
        if (cyc == m_rsp_at) chk("rsp_err", rsp_err, m_err);
        if (m_fresh) begin
          chk("haddr_rst", haddr, '0);
          chk("hwrite_rst", hwrite, 1'b0);
          chk("hwdata_rst", hwdata, '0);
          chk("rsp_err_rst", rsp_err, 1'b0);
        end else if (m_busy && m_issued) begin
          chk("haddr", haddr, m_addr);
          chk("hwrite", hwrite, m_write);
        end
        if (e_data) chk("hwdata", hwdata, m_write ? m_wdata : {DW{1'b0}});
      end
      if (hreset) begin
        m_ok = 1; m_busy = 0; m_issued = 0; m_fresh = 1; m_rdata = '0;
        m_rsp_at = -1; m_gap_at = -1;
      end else if (m_ok) begin
        if (!m_busy) begin
          if (cyc != m_rsp_at && cmd_valid) begin
            m_busy = 1; m_issued = 0; m_fresh = 0; m_retries = 0;
            m_write = cmd_write; m_addr = cmd_addr; m_wdata = cmd_wdata;
            m_req_from = cyc + 1;
          end
        end else if (!m_issued) begin
          if (cyc >= m_req_from && hgrant && hready) begin
            m_issued = 1; m_addr_at = cyc + 1;
          end
        end else if (cyc > m_addr_at && hready) begin
          m_issued = 0;
          case (hresp)
            2'b00: begin
              m_busy = 0; m_rsp_at = cyc + 1; m_err = 0;
              if (!m_write) m_rdata = hrdata;
            end
            2'b01: begin m_busy = 0; m_rsp_at = cyc + 1; m_err = 1; end
            2'b10: begin
              m_retries++;
              if (m_retries >= MR) begin m_busy = 0; m_rsp_at = cyc + 1; m_err = 1; end
              else m_req_from = cyc + 1;
            end
            default: begin m_gap_at = cyc + 1; m_req_from = cyc + 2; end
          endcase
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      output int hs);
    int n;
    n = 0; hs = -1;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    while (hs < 0 && n < 400) begin
      @(negedge hclk);
      if (cmd_ready === 1'b1) hs = cyc;
      n++;
      @(posedge hclk); #1;
    end
    cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom;
    if (hs < 0) begin
      checks++; errors++;
      $display("FAIL handshake got=timeout exp=cmd_ready");
    end
  endtask

  task automatic at(input int c);
    while (cyc < c) @(negedge hclk);
  endtask

  task automatic to_edge(input int c);
    while (cyc < c) begin @(posedge hclk); #1; end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge hclk);
    while (cmd_ready !== 1'b1 && n < 400) begin @(negedge hclk); n++; end
    if (n >= 400) begin
      checks++; errors++;
      $display("FAIL idle_wait got=timeout exp=cmd_ready");
    end
    @(posedge hclk); #1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int h, n;
    repeat (3) @(posedge hclk);
    #1 hreset = 1'b0;
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_hbusreq", hbusreq, 1'b0);
    chk("rst_htrans", htrans, 2'b00);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_haddr", haddr, '0);
    chk("rst_rsp_rdata", rsp_rdata, '0);
    @(posedge hclk); #1;

    // zero-wait write
    push(0, HRESP_OKAY, '0);
    send(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, h);
    at(h + 2); chk("w_haddr", haddr, 32'h10); chk("w_htrans", htrans, 2'b10);
    at(h + 3); chk("w_hwdata", hwdata, 32'hDEAD_BEEF);
    at(h + 4); chk("w_rsp_valid", rsp_valid, 1'b1); chk("w_rsp_err", rsp_err, 1'b0);
    chk("w_no_ready_on_rsp", cmd_ready, 1'b0);
    at(h + 5); chk("w_ready_after", cmd_ready, 1'b1);
    @(posedge hclk); #1;

    // wait-state read
    push(3, HRESP_OKAY, 32'h1234_5678);
    send(1'b0, 32'h20, 32'h0, h);
    at(h + 2); chk("r_haddr_a", haddr, 32'h20);
    at(h + 3); chk("r_hwdata", hwdata, '0);
    at(h + 6); chk("r_haddr_d", haddr, 32'h20); chk("r_no_rsp", rsp_valid, 1'b0);
    at(h + 7); chk("r_rsp_valid", rsp_valid, 1'b1); chk("r_rdata", rsp_rdata, 32'h1234_5678);
    @(posedge hclk); #1;

    // retry limit
    repeat (4) push(0, HRESP_RETRY, 32'hBAD0_0000);
    send(1'b0, 32'h40, 32'h0, h);
    n = 0;
    for (int c = h + 1; c <= h + 13; c++) begin
      at(c);
      if (htrans == 2'b10 && haddr == 32'h40) n++;
    end
    chk("retry_nonseq_count", n, 4);
    chk("retry_rsp_valid", rsp_valid, 1'b1); chk("retry_rsp_err", rsp_err, 1'b1);
    chk("retry_rdata_held", rsp_rdata, 32'h1234_5678);
    @(posedge hclk); #1;

    // retry then okay
    push(0, HRESP_RETRY, '0);
    push(0, HRESP_OKAY, 32'hA5A5_0001);
    send(1'b0, 32'h44, 32'h0, h);
    at(h + 7); chk("retry_ok_valid", rsp_valid, 1'b1); chk("retry_ok_err", rsp_err, 1'b0);
    chk("retry_ok_rdata", rsp_rdata, 32'hA5A5_0001);
    @(posedge hclk); #1;

    // split with grant withheld 10 cycles
    split_block = 10;
    push(0, HRESP_SPLIT, '0);
    push(0, HRESP_OKAY, 32'hCAFE_F00D);
    send(1'b0, 32'h80, 32'h0, h);
    at(h + 4); chk("split_busreq_low", hbusreq, 1'b0);
    at(h + 5); chk("split_busreq_back", hbusreq, 1'b1);
    at(h + 14); chk("split_no_issue", htrans, 2'b00);
    at(h + 15); chk("split_reissue", htrans, 2'b10); chk("split_haddr", haddr, 32'h80);
    at(h + 17); chk("split_rsp_valid", rsp_valid, 1'b1); chk("split_rdata", rsp_rdata, 32'hCAFE_F00D);
    @(posedge hclk); #1;

    // error with grant delayed 5 cycles
    push(0, HRESP_ERROR, 32'hFFFF_FFFF);
    grant_block = 5;
    send(1'b1, 32'h200, 32'h55, h);
    at(h + 5); chk("gd_no_nonseq", htrans, 2'b00);
    at(h + 6); chk("gd_nonseq", htrans, 2'b10);
    at(h + 8); chk("err_rsp_valid", rsp_valid, 1'b1); chk("err_rsp_err", rsp_err, 1'b1);
    chk("err_rdata_held", rsp_rdata, 32'hCAFE_F00D);
    @(posedge hclk); #1;

    // reset while waiting in the data phase
    push(5, HRESP_OKAY, '0);
    send(1'b1, 32'h100, 32'h77, h);
    to_edge(h + 4);
    hreset = 1'b1;
    @(posedge hclk); #1;
    hreset = 1'b0;
    chk("mr_hbusreq", hbusreq, 1'b0); chk("mr_htrans", htrans, 2'b00);
    chk("mr_haddr", haddr, '0); chk("mr_hwrite", hwrite, 1'b0); chk("mr_hwdata", hwdata, '0);
    chk("mr_rsp_valid", rsp_valid, 1'b0); chk("mr_rsp_err", rsp_err, 1'b0);
    chk("mr_rdata", rsp_rdata, '0); chk("mr_cmd_ready", cmd_ready, 1'b1);
    repeat (8) begin @(posedge hclk); #1; end

    // randomised traffic
    grant_random = 1; idle_random = 1; split_rand = 1;
    for (int i = 0; i < 80; i++) begin
      repeat ($urandom_range(0, 3)) begin @(posedge hclk); #1; end
      if (i == 40) begin
        hreset = 1'b1;
        @(posedge hclk); #1;
        hreset = 1'b0;
      end
      send(1'($urandom), $urandom, $urandom, h);
    end
    wait_idle();
    repeat (3) begin @(posedge hclk); #1; end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
